// File: rtl/fetch_prefetch_if.sv
// Signal bundle shared by the fetch front end, the instruction memory port and
// the decode stage. The master side is the fetch unit itself; the slave side is
// the environment (memory plus decode).
interface fetch_prefetch_if;
  // instruction memory request channel
  logic        treqready;
  logic        treqvalid;
  logic [1:0]  treqpriv;
  logic [31:0] treqaddr;
  // instruction memory response channel
  logic        trspready;
  logic        trspvalid;
  logic        trsprerr;
  logic [31:0] trspdata;
  // decode channel
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins_pc;
  logic [31:0] ins_data;
  logic        ins_rerr;

  modport master (
    input  treqready,
    output treqvalid, treqpriv, treqaddr,
    output trspready,
    input  trspvalid, trsprerr, trspdata,
    output ins_valid,
    input  ins_ready,
    output ins_pc, ins_data, ins_rerr
  );

  modport slave (
    output treqready,
    input  treqvalid, treqpriv, treqaddr,
    input  trspready,
    output trspvalid, trsprerr, trspdata,
    input  ins_valid,
    output ins_ready,
    input  ins_pc, ins_data, ins_rerr
  );
endinterface

// File: rtl/fetch_prefetch.sv
// Instruction fetch front end: issues sequential word fetches while buffer
// credit remains, collects responses into a small FIFO tagged with their PC and
// error flag, and hands them to decode. A redirect flushes the buffer and
// discards whatever responses are still in flight for the old stream.
module fetch_prefetch #(
  parameter int unsigned C_FIFO_DEPTHX  = 2,
  parameter logic [31:0] C_RESET_VECTOR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       priv,
  input  logic             redirect,
  input  logic [31:0]      redirect_addr,
  fetch_prefetch_if.master bus
);

  localparam int unsigned DEPTH = 2 ** C_FIFO_DEPTHX;
  localparam int unsigned CW    = C_FIFO_DEPTHX + 1;
  localparam int unsigned PW    = C_FIFO_DEPTHX;

  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] PONE_C  = ONE_C[PW-1:0];
  localparam logic [CW:0]   DEPTH_C = DEPTH[CW:0];

  logic [31:0]   req_pc_q, req_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic          err_mem_q  [DEPTH];

  logic [CW:0]   credit_used_s;
  logic [31:0]   redirect_pc_s;
  logic          treqvalid_s;
  logic          req_fire_s;
  logic          rsp_fire_s;
  logic          drop_s;
  logic          push_s;
  logic          pop_s;
  logic          not_empty_s;
  logic          unused_addr_bits_s;

  // Low address bits of a redirect target are ignored; fold them away here.
  assign unused_addr_bits_s = ^redirect_addr[1:0];
  assign redirect_pc_s      = {redirect_addr[31:2], 2'b00};

  // A request is only issued if its response is guaranteed a FIFO slot, so
  // buffered words plus in-flight words never exceed the buffer depth.
  assign credit_used_s = {1'b0, count_q} + {1'b0, outst_q};
  assign treqvalid_s   = ~reset & ~redirect & (credit_used_s < DEPTH_C);

  assign req_fire_s  = treqvalid_s & bus.treqready;
  // A response with nothing outstanding cannot belong to us and is ignored.
  assign rsp_fire_s  = bus.trspvalid & (outst_q != ZERO_C);
  assign drop_s      = rsp_fire_s & (discard_q != ZERO_C);
  assign push_s      = rsp_fire_s & ~drop_s & ~redirect;
  assign not_empty_s = (count_q != ZERO_C);
  // Redirect wins over a pop in the same cycle.
  assign pop_s       = not_empty_s & bus.ins_ready & ~redirect;

  // Next-state of fetch/response PCs, FIFO bookkeeping and the flush path.
  always_comb begin
    req_pc_d  = req_pc_q;
    rsp_pc_d  = rsp_pc_q;
    count_d   = count_q;
    outst_d   = outst_q;
    discard_d = discard_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (redirect) begin
      // No request can be accepted now, so whatever is still in flight after
      // this cycle's response belongs to the old stream and must be dropped.
      req_pc_d  = redirect_pc_s;
      rsp_pc_d  = redirect_pc_s;
      count_d   = ZERO_C;
      rd_ptr_d  = wr_ptr_q;
      outst_d   = outst_q - (rsp_fire_s ? ONE_C : ZERO_C);
      discard_d = outst_q - (rsp_fire_s ? ONE_C : ZERO_C);
    end else begin
      req_pc_d  = req_fire_s ? (req_pc_q + 32'd4) : req_pc_q;
      rsp_pc_d  = push_s ? (rsp_pc_q + 32'd4) : rsp_pc_q;
      wr_ptr_d  = push_s ? (wr_ptr_q + PONE_C) : wr_ptr_q;
      rd_ptr_d  = pop_s ? (rd_ptr_q + PONE_C) : rd_ptr_q;
      count_d   = count_q + (push_s ? ONE_C : ZERO_C) - (pop_s ? ONE_C : ZERO_C);
      outst_d   = outst_q + (req_fire_s ? ONE_C : ZERO_C) - (rsp_fire_s ? ONE_C : ZERO_C);
      discard_d = drop_s ? (discard_q - ONE_C) : discard_q;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_pc_q  <= C_RESET_VECTOR;
      rsp_pc_q  <= C_RESET_VECTOR;
      count_q   <= ZERO_C;
      outst_q   <= ZERO_C;
      discard_q <= ZERO_C;
      wr_ptr_q  <= {PW{1'b0}};
      rd_ptr_q  <= {PW{1'b0}};
    end else begin
      req_pc_q  <= req_pc_d;
      rsp_pc_q  <= rsp_pc_d;
      count_q   <= count_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // FIFO payload storage; an entry is only read back while it is valid.
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
      data_mem_q[wr_ptr_q] <= bus.trspdata;
      err_mem_q[wr_ptr_q]  <= bus.trsprerr;
    end
  end

  assign bus.treqvalid = treqvalid_s;
  assign bus.treqaddr  = req_pc_q;
  assign bus.treqpriv  = priv;
  assign bus.trspready = 1'b1;

  // Head outputs read as zero while the buffer is empty.
  assign bus.ins_valid = not_empty_s;
  assign bus.ins_pc    = not_empty_s ? pc_mem_q[rd_ptr_q]   : 32'h0000_0000;
  assign bus.ins_data  = not_empty_s ? data_mem_q[rd_ptr_q] : 32'h0000_0000;
  assign bus.ins_rerr  = not_empty_s ? err_mem_q[rd_ptr_q]  : 1'b0;

endmodule

// File: tb/tb_fetch_prefetch.sv
// Self-checking bench for fetch_prefetch. A behavioural memory with selectable
// latency answers requests; delivered words are checked against the expected
// contiguous PC stream of the fetch.
module tb_fetch_prefetch;

  logic        clk;
  logic        reset;
  logic [1:0]  priv;
  logic        redirect;
  logic [31:0] redirect_addr;

  fetch_prefetch_if bus_if ();

  fetch_prefetch #(
    .C_FIFO_DEPTHX (2),
    .C_RESET_VECTOR(32'h0000_0000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .priv         (priv),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .bus          (bus_if)
  );

  int          n_cmp;
  int          n_bad;
  int          lat;
  logic        err_en;
  logic [31:0] err_addr;

  logic [31:0] obs_pc   [$];
  logic [31:0] obs_data [$];
  logic        obs_rerr [$];
  logic [31:0] req_q    [$];

  // memory contents: word i holds 0x13 + 0x80*i
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    mem_word = 32'h13 + {a[26:2], 7'b0000000};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: an accepted request reappears as a response lat cycles later.
  logic [3:0]  st_v;
  logic [31:0] st_a [4];
  always @(posedge clk) begin
    if (reset) begin
      st_v <= 4'b0000;
    end else begin
      st_v     <= {st_v[2:0], bus_if.treqvalid & bus_if.treqready};
      st_a[0]  <= bus_if.treqaddr;
      for (int k = 1; k < 4; k++) st_a[k] <= st_a[k-1];
    end
  end
  assign bus_if.trspvalid = st_v[lat-1];
  assign bus_if.trspdata  = mem_word(st_a[lat-1]);
  assign bus_if.trsprerr  = st_v[lat-1] && err_en && (st_a[lat-1] == err_addr);

  task automatic clear_q();
    obs_pc.delete(); obs_data.delete(); obs_rerr.delete(); req_q.delete();
  endtask

  // log handshakes that complete at the coming rising edge
  task automatic record();
    if (!reset && !redirect && bus_if.ins_valid && bus_if.ins_ready) begin
      obs_pc.push_back(bus_if.ins_pc);
      obs_data.push_back(bus_if.ins_data);
      obs_rerr.push_back(bus_if.ins_rerr);
    end
    if (bus_if.treqvalid && bus_if.treqready) req_q.push_back(bus_if.treqaddr);
  endtask

  task automatic tick();
    #1;
    record();
    @(negedge clk);
  endtask

  task automatic do_reset(input int l, input logic e, input logic [31:0] ea);
    reset = 1'b1; redirect = 1'b0; redirect_addr = 32'h0;
    bus_if.treqready = 1'b1; bus_if.ins_ready = 1'b1;
    tick();
    lat = l; err_en = e; err_addr = ea;
    repeat (3) tick();
    clear_q();
  endtask

  task automatic test_reset();
    do_reset(1, 1'b0, 32'h0);
    #1;
    n_cmp++; if (bus_if.treqvalid !== 1'b0) begin n_bad++; $display("FAIL reset_treqvalid: got %0b want 0", bus_if.treqvalid); end
    n_cmp++; if (bus_if.ins_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ins_valid: got %0b want 0", bus_if.ins_valid); end
    n_cmp++; if (bus_if.ins_pc !== 32'h0) begin n_bad++; $display("FAIL reset_ins_pc: got %h want 0", bus_if.ins_pc); end
    n_cmp++; if (bus_if.ins_data !== 32'h0) begin n_bad++; $display("FAIL reset_ins_data: got %h want 0", bus_if.ins_data); end
    n_cmp++; if (bus_if.ins_rerr !== 1'b0) begin n_bad++; $display("FAIL reset_ins_rerr: got %0b want 0", bus_if.ins_rerr); end
    n_cmp++; if (bus_if.trspready !== 1'b1) begin n_bad++; $display("FAIL reset_trspready: got %0b want 1", bus_if.trspready); end
    @(negedge clk);
  endtask

  task automatic test_stream();
    logic [1:0] p;
    do_reset(1, 1'b0, 32'h0);
    p = 2'($urandom_range(0, 3));
    priv = p;
    reset = 1'b0;
    #1;
    n_cmp++; if (bus_if.treqvalid !== 1'b1 || bus_if.treqaddr !== 32'h0) begin n_bad++; $display("FAIL stream_first_req: got v=%0b a=%h want v=1 a=0", bus_if.treqvalid, bus_if.treqaddr); end
    n_cmp++; if (bus_if.treqpriv !== p) begin n_bad++; $display("FAIL stream_priv: got %0d want %0d", bus_if.treqpriv, p); end
    tick();
    #1;
    n_cmp++; if (bus_if.ins_valid !== 1'b0) begin n_bad++; $display("FAIL stream_early_valid: got %0b want 0", bus_if.ins_valid); end
    tick();
    #1;
    n_cmp++; if (bus_if.ins_valid !== 1'b1 || bus_if.ins_pc !== 32'h0 || bus_if.ins_data !== 32'h13 || bus_if.ins_rerr !== 1'b0) begin
      n_bad++; $display("FAIL stream_first_word: got v=%0b pc=%h d=%h e=%0b want v=1 pc=0 d=13 e=0", bus_if.ins_valid, bus_if.ins_pc, bus_if.ins_data, bus_if.ins_rerr);
    end
    tick();
    repeat (17) tick();
    n_cmp++; if (req_q.size() != 20) begin n_bad++; $display("FAIL stream_req_count: got %0d want 20", req_q.size()); end
    for (int i = 0; i < req_q.size(); i++) begin
      n_cmp++; if (req_q[i] !== 32'(4 * i)) begin n_bad++; $display("FAIL stream_req_addr[%0d]: got %h want %h", i, req_q[i], 32'(4 * i)); end
    end
    n_cmp++; if (obs_pc.size() != 18) begin n_bad++; $display("FAIL stream_pop_count: got %0d want 18", obs_pc.size()); end
    for (int i = 0; i < obs_pc.size(); i++) begin
      n_cmp++; if (obs_pc[i] !== 32'(4 * i) || obs_data[i] !== mem_word(32'(4 * i))) begin
        n_bad++; $display("FAIL stream_word[%0d]: got pc=%h d=%h want pc=%h d=%h", i, obs_pc[i], obs_data[i], 32'(4 * i), mem_word(32'(4 * i)));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1, 1'b0, 32'h0);
    bus_if.ins_ready = 1'b0;
    reset = 1'b0;
    repeat (10) tick();
    #1;
    n_cmp++; if (bus_if.treqvalid !== 1'b0) begin n_bad++; $display("FAIL bp_treqvalid_full: got %0b want 0", bus_if.treqvalid); end
    n_cmp++; if (req_q.size() != 4) begin n_bad++; $display("FAIL bp_req_count: got %0d want 4", req_q.size()); end
    n_cmp++; if (obs_pc.size() != 0) begin n_bad++; $display("FAIL bp_pops_while_stalled: got %0d want 0", obs_pc.size()); end
    bus_if.ins_ready = 1'b1;
    repeat (20) tick();
    n_cmp++; if (obs_pc.size() != 20) begin n_bad++; $display("FAIL bp_drain_count: got %0d want 20", obs_pc.size()); end
    for (int i = 0; i < obs_pc.size(); i++) begin
      n_cmp++; if (obs_pc[i] !== 32'(4 * i) || obs_data[i] !== mem_word(32'(4 * i))) begin
        n_bad++; $display("FAIL bp_word[%0d]: got pc=%h d=%h want pc=%h", i, obs_pc[i], obs_data[i], 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect();
    do_reset(2, 1'b0, 32'h0);
    reset = 1'b0;
    repeat (8) tick();
    n_cmp++; if (obs_pc.size() < 3) begin n_bad++; $display("FAIL redir_pre_count: got %0d want >=3", obs_pc.size()); end
    for (int i = 0; i < obs_pc.size(); i++) begin
      n_cmp++; if (obs_pc[i] !== 32'(4 * i)) begin n_bad++; $display("FAIL redir_pre_pc[%0d]: got %h want %h", i, obs_pc[i], 32'(4 * i)); end
    end
    clear_q();
    redirect = 1'b1; redirect_addr = 32'h0000_0103;
    #1;
    n_cmp++; if (bus_if.treqvalid !== 1'b0) begin n_bad++; $display("FAIL redir_treqvalid: got %0b want 0", bus_if.treqvalid); end
    tick();
    redirect = 1'b0;
    #1;
    n_cmp++; if (bus_if.ins_valid !== 1'b0) begin n_bad++; $display("FAIL redir_flush_valid: got %0b want 0", bus_if.ins_valid); end
    repeat (14) tick();
    n_cmp++; if (req_q.size() == 0 || req_q[0] !== 32'h100) begin n_bad++; $display("FAIL redir_first_req: got %h want 100", (req_q.size() == 0) ? 32'hFFFF_FFFF : req_q[0]); end
    n_cmp++; if (obs_pc.size() < 8) begin n_bad++; $display("FAIL redir_post_count: got %0d want >=8", obs_pc.size()); end
    for (int i = 0; i < obs_pc.size(); i++) begin
      n_cmp++; if (obs_pc[i] !== 32'h100 + 32'(4 * i) || obs_data[i] !== mem_word(32'h100 + 32'(4 * i))) begin
        n_bad++; $display("FAIL redir_post_word[%0d]: got pc=%h d=%h want pc=%h", i, obs_pc[i], obs_data[i], 32'h100 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_wrap();
    do_reset(1, 1'b0, 32'h0);
    reset = 1'b0;
    redirect = 1'b1; redirect_addr = 32'hFFFF_FFFA;
    tick();
    redirect = 1'b0;
    repeat (10) tick();
    n_cmp++; if (req_q.size() == 0 || req_q[0] !== 32'hFFFF_FFF8) begin n_bad++; $display("FAIL wrap_first_req: got %h want fffffff8", (req_q.size() == 0) ? 32'h0 : req_q[0]); end
    n_cmp++; if (obs_pc.size() < 4) begin n_bad++; $display("FAIL wrap_count: got %0d want >=4", obs_pc.size()); end
    for (int i = 0; i < obs_pc.size(); i++) begin
      n_cmp++; if (obs_pc[i] !== 32'hFFFF_FFF8 + 32'(4 * i)) begin n_bad++; $display("FAIL wrap_pc[%0d]: got %h want %h", i, obs_pc[i], 32'hFFFF_FFF8 + 32'(4 * i)); end
    end
  endtask

  task automatic test_rerr();
    do_reset(1, 1'b1, 32'h8);
    reset = 1'b0;
    repeat (10) tick();
    n_cmp++; if (obs_pc.size() < 4) begin n_bad++; $display("FAIL rerr_count: got %0d want >=4", obs_pc.size()); end
    for (int i = 0; i < obs_pc.size(); i++) begin
      n_cmp++; if (obs_pc[i] !== 32'(4 * i) || obs_rerr[i] !== (32'(4 * i) == 32'h8)) begin
        n_bad++; $display("FAIL rerr_word[%0d]: got pc=%h e=%0b want pc=%h e=%0b", i, obs_pc[i], obs_rerr[i], 32'(4 * i), (32'(4 * i) == 32'h8));
      end
    end
  endtask

  task automatic test_random();
    logic        prev_stall;
    logic [31:0] prev_addr;
    do_reset(1 + int'($urandom_range(0, 2)), 1'b0, 32'h0);
    reset = 1'b0;
    prev_stall = 1'b0;
    prev_addr  = 32'h0;
    for (int c = 0; c < 400; c++) begin
      bus_if.treqready = ($urandom_range(0, 9) != 0);
      bus_if.ins_ready = 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) begin
        n_cmp++; if (bus_if.treqvalid !== 1'b1 || bus_if.treqaddr !== prev_addr) begin
          n_bad++; $display("FAIL rand_req_stable: got v=%0b a=%h want v=1 a=%h", bus_if.treqvalid, bus_if.treqaddr, prev_addr);
        end
      end
      prev_stall = bus_if.treqvalid && !bus_if.treqready;
      prev_addr  = bus_if.treqaddr;
      record();
      @(negedge clk);
    end
    bus_if.treqready = 1'b1; bus_if.ins_ready = 1'b1;
    repeat (10) tick();
    n_cmp++; if (obs_pc.size() < 100) begin n_bad++; $display("FAIL rand_count: got %0d want >=100", obs_pc.size()); end
    for (int i = 0; i < req_q.size(); i++) begin
      n_cmp++; if (req_q[i] !== 32'(4 * i)) begin n_bad++; $display("FAIL rand_req[%0d]: got %h want %h", i, req_q[i], 32'(4 * i)); end
    end
    for (int i = 0; i < obs_pc.size(); i++) begin
      n_cmp++; if (obs_pc[i] !== 32'(4 * i) || obs_data[i] !== mem_word(32'(4 * i)) || obs_rerr[i] !== 1'b0) begin
        n_bad++; $display("FAIL rand_word[%0d]: got pc=%h d=%h e=%0b want pc=%h", i, obs_pc[i], obs_data[i], obs_rerr[i], 32'(4 * i));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1, 1'b0, 32'h0);
    bus_if.ins_ready = 1'b0;
    reset = 1'b0;
    repeat (10) tick();
    #1;
    n_cmp++; if (bus_if.ins_valid !== 1'b1 || bus_if.treqvalid !== 1'b0) begin
      n_bad++; $display("FAIL rmid_full: got v=%0b rq=%0b want v=1 rq=0", bus_if.ins_valid, bus_if.treqvalid);
    end
    reset = 1'b1;
    tick();
    #1;
    n_cmp++; if (bus_if.ins_valid !== 1'b0 || bus_if.treqvalid !== 1'b0 || bus_if.ins_pc !== 32'h0) begin
      n_bad++; $display("FAIL rmid_cleared: got v=%0b rq=%0b pc=%h want 0 0 0", bus_if.ins_valid, bus_if.treqvalid, bus_if.ins_pc);
    end
    tick();
    clear_q();
    reset = 1'b0;
    bus_if.ins_ready = 1'b1;
    #1;
    n_cmp++; if (bus_if.treqvalid !== 1'b1 || bus_if.treqaddr !== 32'h0) begin
      n_bad++; $display("FAIL rmid_restart: got v=%0b a=%h want v=1 a=0", bus_if.treqvalid, bus_if.treqaddr);
    end
    repeat (6) tick();
    n_cmp++; if (obs_pc.size() == 0 || obs_pc[0] !== 32'h0) begin
      n_bad++; $display("FAIL rmid_first_pop: got %h want 0", (obs_pc.size() == 0) ? 32'hFFFF_FFFF : obs_pc[0]);
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    lat = 1; err_en = 1'b0; err_addr = 32'h0;
    reset = 1'b1; priv = 2'b00; redirect = 1'b0; redirect_addr = 32'h0;
    bus_if.treqready = 1'b1; bus_if.ins_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_rerr();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
